// File: rtl/pad_bus_scheduler_if.sv
// rtl/pad_bus_scheduler_if.sv - core, secondary requester and pad bus signals of the scheduler
interface pad_bus_scheduler_if;
  // core pipeline side
  logic [31:0] pc_address;
  logic [31:0] data_address;
  logic        core_load;
  logic        core_store;
  logic [1:0]  core_size;
  logic [1:0]  phase;
  // secondary requester side
  logic        dma_request;
  logic        dma_write;
  logic [31:0] dma_address;
  logic [1:0]  dma_size;
  logic        dma_grant;
  logic        dma_done;
  // pad bus side
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic        bus_ready;
  logic        bus_error;

  // scheduler view: owns the bus command and the phase strobes
  modport master (
    input  pc_address, data_address, core_load, core_store, core_size,
    input  dma_request, dma_write, dma_address, dma_size, bus_ready,
    output phase, dma_grant, dma_done,
    output bus_address, bus_read, bus_write, bus_size, bus_error
  );

  // environment view: core, requester and pad bus model
  modport slave (
    output pc_address, data_address, core_load, core_store, core_size,
    output dma_request, dma_write, dma_address, dma_size, bus_ready,
    input  phase, dma_grant, dma_done,
    input  bus_address, bus_read, bus_write, bus_size, bus_error
  );
endinterface

// File: rtl/pad_bus_scheduler.sv
// rtl/pad_bus_scheduler.sv - pad bus sequencer for the two-phase core plus one secondary requester
module pad_bus_scheduler #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic                  clock,
  input logic                  reset,
  pad_bus_scheduler_if.master  pads
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DMA   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_count;

  logic        cmd;
  logic        complete;
  logic        timeout;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [1:0]  size;
  logic [1:0]  phase;
  logic        grant;
  logic        done;

  // Command, completion and strobes are combinational so the pulses land on the ready cycle;
  // reset masks everything so an interrupted access produces no completion.
  always_comb begin
    cmd        = 1'b0;
    rd         = 1'b0;
    wr         = 1'b0;
    addr       = 32'd0;
    size       = 2'd0;
    grant      = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    phase      = 2'b00;
    done       = 1'b0;
    next_state = ST_FETCH;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          cmd        = 1'b1;
          rd         = 1'b1;
          addr       = pads.pc_address;
          size       = 2'b10;
          next_state = ST_EXEC;
        end
        ST_EXEC: begin
          // store has priority over a simultaneous load
          if (pads.core_store) begin
            cmd  = 1'b1;
            wr   = 1'b1;
            addr = pads.data_address;
            size = pads.core_size;
          end else if (pads.core_load) begin
            cmd  = 1'b1;
            rd   = 1'b1;
            addr = pads.data_address;
            size = pads.core_size;
          end else begin
            complete = 1'b1;
          end
          next_state = pads.dma_request ? ST_DMA : ST_FETCH;
        end
        ST_DMA: begin
          cmd        = 1'b1;
          grant      = 1'b1;
          wr         = pads.dma_write;
          rd         = !pads.dma_write;
          addr       = pads.dma_address;
          size       = pads.dma_size;
          next_state = ST_FETCH;
        end
        default: next_state = ST_FETCH;
      endcase
      if (cmd) begin
        timeout  = !pads.bus_ready && (wait_count == LAST_WAIT);
        complete = pads.bus_ready || timeout;
      end
      if (complete) begin
        case (state)
          ST_FETCH: phase = 2'b01;
          ST_EXEC:  phase = 2'b10;
          ST_DMA:   done  = 1'b1;
          default:  phase = 2'b00;
        endcase
      end
    end
  end

  // Drive the interface outputs from the decoded command.
  always_comb begin
    pads.phase       = phase;
    pads.dma_grant   = grant;
    pads.dma_done    = done;
    pads.bus_address = addr;
    pads.bus_read    = rd;
    pads.bus_write   = wr;
    pads.bus_size    = size;
    pads.bus_error   = timeout;
  end

  // Advance on completion (the wait counter restarts with each state entry) and count stalled command cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_FETCH;
      wait_count <= 8'd0;
    end else if (complete) begin
      state      <= next_state;
      wait_count <= 8'd0;
    end else if (cmd && !pads.bus_ready) begin
      wait_count <= wait_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pad_bus_scheduler.sv
// tb/tb_pad_bus_scheduler.sv - directed self-checking bench for pad_bus_scheduler
module tb_pad_bus_scheduler;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  pad_bus_scheduler_if pads ();

  pad_bus_scheduler #(.TIMEOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .pads  (pads)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compares every scheduler output in the current cycle.
  task automatic cyc(input string tag, input logic [1:0] ph, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [1:0] sz, input logic gr,
                     input logic dn, input logic er);
    #1;
    check({tag, ".phase"}, 32'(pads.phase), 32'(ph));
    check({tag, ".read"},  32'(pads.bus_read), 32'(rd));
    check({tag, ".write"}, 32'(pads.bus_write), 32'(wr));
    check({tag, ".addr"},  pads.bus_address, addr);
    check({tag, ".size"},  32'(pads.bus_size), 32'(sz));
    check({tag, ".grant"}, 32'(pads.dma_grant), 32'(gr));
    check({tag, ".done"},  32'(pads.dma_done), 32'(dn));
    check({tag, ".error"}, 32'(pads.bus_error), 32'(er));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    pads.pc_address   = 32'h0;
    pads.data_address = 32'h0;
    pads.core_load    = 1'b0;
    pads.core_store   = 1'b0;
    pads.core_size    = 2'b00;
    pads.dma_request  = 1'b0;
    pads.dma_write    = 1'b0;
    pads.dma_address  = 32'h0;
    pads.dma_size     = 2'b00;
    pads.bus_ready    = 1'b0;

    // reset cycle: everything quiet even with ready high
    step();
    cyc("rst0", 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    pads.pc_address = 32'h100;
    pads.bus_ready  = 1'b1;
    cyc("rst1", 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    reset = 1'b0;

    // zero-wait run
    cyc("zw_f0", 2'b01, 1, 0, 32'h100, 2'b10, 0, 0, 0);
    step();
    cyc("zw_e0", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();
    pads.pc_address = 32'h104;
    cyc("zw_f1", 2'b01, 1, 0, 32'h104, 2'b10, 0, 0, 0);
    step();
    cyc("zw_e1", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();

    // fetch with two wait states
    pads.pc_address = 32'h108;
    pads.bus_ready  = 1'b0;
    cyc("fw_w1", 2'b00, 1, 0, 32'h108, 2'b10, 0, 0, 0);
    step();
    cyc("fw_w2", 2'b00, 1, 0, 32'h108, 2'b10, 0, 0, 0);
    step();
    pads.bus_ready = 1'b1;
    cyc("fw_ok", 2'b01, 1, 0, 32'h108, 2'b10, 0, 0, 0);
    step();
    cyc("fw_e", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();

    // store with one wait state, simultaneous load ignored
    pads.pc_address = 32'h10C;
    cyc("st_f", 2'b01, 1, 0, 32'h10C, 2'b10, 0, 0, 0);
    step();
    pads.core_store   = 1'b1;
    pads.core_load    = 1'b1;
    pads.data_address = 32'h0000_1000;
    pads.core_size    = 2'b01;
    pads.bus_ready    = 1'b0;
    cyc("st_w1", 2'b00, 0, 1, 32'h1000, 2'b01, 0, 0, 0);
    step();
    pads.bus_ready = 1'b1;
    cyc("st_ok", 2'b10, 0, 1, 32'h1000, 2'b01, 0, 0, 0);
    step();
    pads.core_store = 1'b0;
    pads.core_load  = 1'b0;

    // DMA insertion, one transfer per instruction
    pads.pc_address = 32'h110;
    cyc("dm_f0", 2'b01, 1, 0, 32'h110, 2'b10, 0, 0, 0);
    step();
    pads.dma_request = 1'b1;
    pads.dma_address = 32'h2000;
    pads.dma_size    = 2'b11;
    pads.dma_write   = 1'b0;
    cyc("dm_e0", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();
    cyc("dm_x0", 2'b00, 1, 0, 32'h2000, 2'b11, 1, 1, 0);
    step();
    pads.pc_address = 32'h114;
    cyc("dm_f1", 2'b01, 1, 0, 32'h114, 2'b10, 0, 0, 0);
    step();
    cyc("dm_e1", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();
    pads.dma_write = 1'b1;
    cyc("dm_x1", 2'b00, 0, 1, 32'h2000, 2'b11, 1, 1, 0);
    step();
    pads.pc_address = 32'h118;
    cyc("dm_f2", 2'b01, 1, 0, 32'h118, 2'b10, 0, 0, 0);
    step();
    pads.dma_request = 1'b0;
    cyc("dm_e2", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();

    // watchdog at four command cycles without ready
    pads.pc_address = 32'h11C;
    pads.bus_ready  = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc($sformatf("wd_w%0d", i), 2'b00, 1, 0, 32'h11C, 2'b10, 0, 0, 0);
      step();
    end
    cyc("wd_to", 2'b01, 1, 0, 32'h11C, 2'b10, 0, 0, 1);
    step();
    pads.bus_ready = 1'b1;
    cyc("wd_e", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();

    // reset during the third wait cycle of a DMA transfer
    pads.pc_address = 32'h120;
    cyc("rd_f", 2'b01, 1, 0, 32'h120, 2'b10, 0, 0, 0);
    step();
    pads.dma_request = 1'b1;
    pads.dma_write   = 1'b0;
    pads.dma_size    = 2'b10;
    cyc("rd_e", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();
    pads.bus_ready = 1'b0;
    cyc("rd_w1", 2'b00, 1, 0, 32'h2000, 2'b10, 1, 0, 0);
    step();
    pads.dma_request = 1'b0;
    cyc("rd_w2", 2'b00, 1, 0, 32'h2000, 2'b10, 1, 0, 0);
    step();
    reset = 1'b1;
    cyc("rd_w3", 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();
    pads.bus_ready = 1'b1;
    cyc("rd_hold", 2'b00, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();
    reset = 1'b0;
    pads.pc_address = 32'h200;
    cyc("rd_f2", 2'b01, 1, 0, 32'h200, 2'b10, 0, 0, 0);
    step();
    cyc("rd_e2", 2'b10, 0, 0, 32'h0, 2'b00, 0, 0, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
